// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared width codes, FSM encoding, opcodes and alignment helper
package mem_access_unit_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   typedef enum logic [6:0] {
      OP_LOAD  = 7'b0000011,
      OP_STORE = 7'b0100011
   } opcode_e;

   // Size code 2'b11 is handled as a word everywhere, so it follows the word alignment rule.
   function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
      return (sz == SZ_H && a[0]) || (sz >= SZ_W && a != 2'b00);
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: req/ack data-memory port between the access unit and memory
interface mem_access_unit_if #(parameter int ADDR_W = 10);

   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic [3:0]        be;
   logic [31:0]       rdata;
   logic              ack;

   modport master (output req, we, addr, wdata, be, input rdata, ack);
   modport slave  (input req, we, addr, wdata, be, output rdata, ack);

endinterface

// File: rtl/mem_lane_fmt.sv
// mem_lane_fmt: byte-lane enables, store replication and load extract/extend
module mem_lane_fmt
   import mem_access_unit_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        uns,
   input  logic [1:0]  a,
   input  logic [31:0] wdin,
   input  logic [31:0] rdin,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] rdata
);

   logic [15:0] sel;

   // Lane selection is a pure function of size and the low address bits.
   always_comb begin
      sel   = 16'(rdin >> {a, 3'b000});
      be    = size == SZ_B ? 4'b0001 << a : size == SZ_H ? 4'b0011 << a : 4'b1111;
      wdata = size == SZ_B ? {4{wdin[7:0]}} : size == SZ_H ? {2{wdin[15:0]}} : wdin;
      rdata = size == SZ_B ? {{24{~uns & sel[7]}}, sel[7:0]} :
              size == SZ_H ? {{16{~uns & sel[15]}}, sel[15:0]} : rdin;
   end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store sequencer onto the req/ack data-memory port
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int TIMEOUT = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [31:0]         MEM_ALU_OUT,
   input  logic [31:0]         MEM_rs2,
   input  logic [31:0]         MEM_INST,
   input  logic                MEM_memread,
   input  logic                MEM_memwrite,
   input  logic                MEM_FLUSH,
   mem_access_unit_if.master   dm,
   output logic [31:0]         MEM_Data_mem_out,
   output logic                mem_stall,
   output logic                mem_err
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [1:0]    state;
   logic [CW-1:0] tmo_cnt;
   logic [2:0]    r_f3;
   logic [1:0]    r_a;
   logic          kill;
   logic [2:0]    f3;
   logic          access;
   logic          mis;
   logic          drop;
   logic [3:0]    be_n;
   logic [31:0]   wdata_n;
   logic [31:0]   load_val;
   logic [31:0]   unused_req_rdata;
   logic [3:0]    unused_rsp_be;
   logic [31:0]   unused_rsp_wdata;
   logic          unused_bits;

   assign f3          = MEM_INST[14:12];
   assign access      = (MEM_memread | MEM_memwrite) & ~MEM_FLUSH;
   assign mis         = misaligned(f3[1:0], MEM_ALU_OUT[1:0]);
   assign drop        = kill | MEM_FLUSH;
   assign dm.req      = state == S_WAIT;
   assign mem_stall   = rst & ((state == S_IDLE & access & ~mis) | state == S_WAIT);
   assign unused_bits = ^{MEM_INST[31:15], MEM_INST[11:0], MEM_ALU_OUT[31:ADDR_W+2], unused_req_rdata,
                          unused_rsp_be, unused_rsp_wdata};

   mem_lane_fmt u_req_fmt (
      .size(f3[1:0]), .uns(f3[2]), .a(MEM_ALU_OUT[1:0]), .wdin(MEM_rs2), .rdin(32'd0),
      .be(be_n), .wdata(wdata_n), .rdata(unused_req_rdata)
   );

   mem_lane_fmt u_rsp_fmt (
      .size(r_f3[1:0]), .uns(r_f3[2]), .a(r_a), .wdin(32'd0), .rdin(dm.rdata),
      .be(unused_rsp_be), .wdata(unused_rsp_wdata), .rdata(load_val)
   );

   // IDLE launches or rejects an access, WAIT holds the request until ack/timeout, DONE releases the pipe once.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state            <= S_IDLE;
         tmo_cnt          <= '0;
         r_f3             <= '0;
         r_a              <= '0;
         kill             <= 1'b0;
         dm.we            <= 1'b0;
         dm.addr          <= '0;
         dm.wdata         <= '0;
         dm.be            <= '0;
         MEM_Data_mem_out <= '0;
         mem_err          <= 1'b0;
      end else begin
         mem_err <= 1'b0;
         if (state == S_IDLE) begin
            if (access && mis) begin
               mem_err          <= 1'b1;
               MEM_Data_mem_out <= '0;
            end else if (access) begin
               state    <= S_WAIT;
               tmo_cnt  <= '0;
               kill     <= 1'b0;
               dm.we    <= MEM_memwrite;
               dm.addr  <= MEM_ALU_OUT[ADDR_W+1:2];
               dm.wdata <= wdata_n;
               dm.be    <= be_n;
               r_f3     <= f3;
               r_a      <= MEM_ALU_OUT[1:0];
            end
         end else if (state == S_WAIT) begin
            tmo_cnt <= tmo_cnt + 1'b1;
            kill    <= drop;
            if (dm.ack) begin
               state            <= S_DONE;
               MEM_Data_mem_out <= (dm.we | drop) ? 32'd0 : load_val;
            end else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
               state            <= S_DONE;
               mem_err          <= ~drop;
               MEM_Data_mem_out <= '0;
            end
         end else begin
            state <= S_IDLE;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table-driven scoreboard bench for the MEM-stage access unit
module tb_mem_access_unit;
   import mem_access_unit_pkg::*;

   localparam int TMO = 4;

   typedef struct {
      bit          mis;
      bit          rd;
      bit          wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] rs2;
      logic [31:0] rdata;
      int          ack_at;
      int          flush_at;
      logic        exp_we;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
      logic [31:0] exp_data;
      logic        exp_err;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] MEM_ALU_OUT = '0;
   logic [31:0] MEM_rs2 = '0;
   logic [31:0] MEM_INST = '0;
   logic        MEM_memread = 1'b0;
   logic        MEM_memwrite = 1'b0;
   logic        MEM_FLUSH = 1'b0;
   logic [31:0] MEM_Data_mem_out;
   logic        mem_stall;
   logic        mem_err;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t sb_q[$];
   vec_t tv[14];

   mem_access_unit_if #(.ADDR_W(10)) dm ();

   mem_access_unit #(.ADDR_W(10), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .MEM_ALU_OUT(MEM_ALU_OUT), .MEM_rs2(MEM_rs2), .MEM_INST(MEM_INST),
      .MEM_memread(MEM_memread), .MEM_memwrite(MEM_memwrite), .MEM_FLUSH(MEM_FLUSH), .dm(dm),
      .MEM_Data_mem_out(MEM_Data_mem_out), .mem_stall(mem_stall), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      MEM_memread  = 1'b0;
      MEM_memwrite = 1'b0;
      MEM_FLUSH    = 1'b0;
   endtask

   task automatic pop_chk(input string tag);
      exp_t e;
      if (sb_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_sb: got empty queue expected entry", tag);
      end else begin
         e = sb_q.pop_front();
         chk({tag, "_data"}, MEM_Data_mem_out, e.data);
         chk({tag, "_err"}, {31'd0, mem_err}, {31'd0, e.err});
      end
   endtask

   task automatic run(input int idx, input vec_t v);
      string tag;
      int    stalls;
      int    waits;
      bit    done;
      tag = $sformatf("v%0d", idx);
      @(negedge clk);
      MEM_memread  = v.rd;
      MEM_memwrite = v.wr;
      MEM_INST     = {17'd0, v.f3, 5'd0, v.wr ? OP_STORE : OP_LOAD};
      MEM_ALU_OUT  = v.addr;
      MEM_rs2      = v.rs2;
      sb_q.push_back('{v.exp_data, v.exp_err});
      #1;
      if (v.mis) begin
         chk({tag, "_stall"}, {31'd0, mem_stall}, 32'd0);
         chk({tag, "_req"}, {31'd0, dm.req}, 32'd0);
         @(negedge clk);
         idle_inputs();
         #1;
         chk({tag, "_req2"}, {31'd0, dm.req}, 32'd0);
         pop_chk(tag);
      end else begin
         chk({tag, "_stall0"}, {31'd0, mem_stall}, 32'd1);
         stalls = 1;
         waits  = 0;
         done   = 0;
         for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            dm.ack = 1'b0;
            if (mem_stall) begin
               stalls++;
               waits++;
               if (waits == 1) begin
                  chk({tag, "_req"}, {31'd0, dm.req}, 32'd1);
                  chk({tag, "_we"}, {31'd0, dm.we}, {31'd0, v.exp_we});
                  chk({tag, "_addr"}, {22'd0, dm.addr}, {22'd0, v.addr[11:2]});
                  chk({tag, "_be"}, {28'd0, dm.be}, {28'd0, v.exp_be});
                  chk({tag, "_wdata"}, dm.wdata, v.exp_wdata);
               end
               if (waits == v.flush_at) MEM_FLUSH = 1'b1;
               if (waits == v.ack_at) begin
                  dm.ack   = 1'b1;
                  dm.rdata = v.rdata;
               end
            end else begin
               done = 1;
            end
         end
         chk({tag, "_done"}, {31'd0, done}, 32'd1);
         chk({tag, "_stalls"}, stalls, 1 + (v.ack_at == 0 ? TMO : v.ack_at));
         chk({tag, "_req_done"}, {31'd0, dm.req}, 32'd0);
         pop_chk(tag);
         idle_inputs();
      end
      @(negedge clk);
      chk({tag, "_err_pulse"}, {31'd0, mem_err}, 32'd0);
   endtask

   initial begin
      dm.ack   = 1'b0;
      dm.rdata = '0;
      tv[0]  = '{0, 0, 1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        3, 0, 1, 4'b1111, 32'hDEADBEEF, 32'h0,        0};
      tv[1]  = '{0, 1, 0, 3'b000, 32'h13,  32'h0,        32'h80FF0000, 1, 0, 0, 4'b1000, 32'h0,        32'hFFFFFF80, 0};
      tv[2]  = '{0, 1, 0, 3'b100, 32'h13,  32'h0,        32'h80FF0000, 1, 0, 0, 4'b1000, 32'h0,        32'h00000080, 0};
      tv[3]  = '{0, 1, 0, 3'b001, 32'h02,  32'h0,        32'h80011234, 2, 0, 0, 4'b1100, 32'h0,        32'hFFFF8001, 0};
      tv[4]  = '{1, 1, 0, 3'b001, 32'h01,  32'h0,        32'h0,        0, 0, 0, 4'b0000, 32'h0,        32'h0,        1};
      tv[5]  = '{0, 1, 0, 3'b010, 32'h20,  32'h0,        32'h0,        0, 0, 0, 4'b1111, 32'h0,        32'h0,        1};
      tv[6]  = '{0, 1, 0, 3'b010, 32'h24,  32'h0,        32'h12345678, 2, 1, 0, 4'b1111, 32'h0,        32'h0,        0};
      tv[7]  = '{0, 0, 1, 3'b000, 32'h05,  32'h000000A5, 32'h0,        1, 0, 1, 4'b0010, 32'hA5A5A5A5, 32'h0,        0};
      tv[8]  = '{0, 0, 1, 3'b001, 32'h06,  32'h0000BEEF, 32'h0,        1, 0, 1, 4'b1100, 32'hBEEFBEEF, 32'h0,        0};
      tv[9]  = '{0, 1, 0, 3'b101, 32'h02,  32'h0,        32'h80011234, 1, 0, 0, 4'b1100, 32'h0,        32'h00008001, 0};
      tv[10] = '{0, 1, 0, 3'b010, 32'h3FC, 32'h0,        32'hCAFEF00D, 1, 0, 0, 4'b1111, 32'h0,        32'hCAFEF00D, 0};
      tv[11] = '{0, 1, 1, 3'b010, 32'h08,  32'h11223344, 32'hFFFFFFFF, 1, 0, 1, 4'b1111, 32'h11223344, 32'h0,        0};
      tv[12] = '{1, 1, 0, 3'b010, 32'h0A,  32'h0,        32'h0,        0, 0, 0, 4'b0000, 32'h0,        32'h0,        1};
      tv[13] = '{0, 1, 0, 3'b000, 32'h01,  32'h0,        32'h00007F00, 1, 0, 0, 4'b0010, 32'h0,        32'h0000007F, 0};

      MEM_memread = 1'b1;
      MEM_INST    = {17'd0, 3'b010, 5'd0, OP_LOAD};
      repeat (2) @(negedge clk);
      chk("rst_stall", {31'd0, mem_stall}, 32'd0);
      chk("rst_req", {31'd0, dm.req}, 32'd0);
      chk("rst_err", {31'd0, mem_err}, 32'd0);
      chk("rst_data", MEM_Data_mem_out, 32'd0);
      idle_inputs();
      rst = 1'b1;

      for (int i = 0; i < 14; i++) run(i, tv[i]);

      @(negedge clk);
      dm.ack   = 1'b1;
      dm.rdata = 32'hFFFFFFFF;
      @(negedge clk);
      dm.ack = 1'b0;
      chk("stray_ack_data", MEM_Data_mem_out, 32'h0000007F);
      chk("stray_ack_stall", {31'd0, mem_stall}, 32'd0);
      chk("stray_ack_err", {31'd0, mem_err}, 32'd0);

      @(negedge clk);
      MEM_memread = 1'b1;
      MEM_INST    = {17'd0, 3'b010, 5'd0, OP_LOAD};
      MEM_ALU_OUT = 32'h40;
      @(negedge clk);
      chk("wrst_req_pre", {31'd0, dm.req}, 32'd1);
      rst = 1'b0;
      idle_inputs();
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("wrst_req", {31'd0, dm.req}, 32'd0);
      chk("wrst_stall", {31'd0, mem_stall}, 32'd0);
      chk("wrst_data", MEM_Data_mem_out, 32'd0);
      dm.ack   = 1'b1;
      dm.rdata = 32'h55555555;
      @(negedge clk);
      dm.ack = 1'b0;
      chk("wrst_ack_req", {31'd0, dm.req}, 32'd0);
      chk("wrst_ack_stall", {31'd0, mem_stall}, 32'd0);
      chk("wrst_ack_data", MEM_Data_mem_out, 32'd0);
      chk("wrst_ack_err", {31'd0, mem_err}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
